// File: rtl/term_monitor_multi.sv
// term_monitor_multi
// Multi-core termination monitor for OpTiMSoC compute tiles. Watches each
// mor1kx trace stream for the simulation-exit instruction (l.nop NOP_EXIT),
// latches that core's r3 exit code, and once every core has exited waits a
// drain period before reporting a system-wide done. An activity watchdog
// flags a hung system, and latched exit codes can be read back by index.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   trace_valid      per-core retired-instruction strobe
//   trace_insn       per-core retired instruction, core i at [32*i +: 32]
//   trace_r3         per-core current r3 value, core i at [32*i +: 32]
//   clear            synchronous restart of monitoring
//   done_mask        sticky per-core terminated flags
//   all_done         all cores exited and drain elapsed
//   any_fail         at least one latched exit code is nonzero
//   first_fail_idx   index of the earliest core to exit with a nonzero code
//   timeout          watchdog expired
//   rd_idx           exit-code readback index
//   rd_code          exit code of core rd_idx (1-cycle latency)
//   rd_stamp         exit cycle stamp of core rd_idx (optional)
//
// Optional feature macro: TERM_MONITOR_CYCLE_STAMP_EN adds a saturating
// cycle counter, per-core exit stamps and the rd_stamp output.

module term_monitor_multi #(
    parameter int          NUM_CORES    = 36,
    parameter logic [15:0] NOP_EXIT     = 16'h0001,
    parameter int          DRAIN_CYCLES = 16,
    parameter int          WDOG_CYCLES  = 1000000,
    parameter int          IDX_W        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CORES-1:0]      trace_valid,
    input  logic [NUM_CORES*32-1:0]   trace_insn,
    input  logic [NUM_CORES*32-1:0]   trace_r3,
    input  logic                      clear,
    output logic [NUM_CORES-1:0]      done_mask,
    output logic                      all_done,
    output logic                      any_fail,
    output logic [IDX_W-1:0]          first_fail_idx,
    output logic                      timeout,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [31:0]               rd_code
`ifdef TERM_MONITOR_CYCLE_STAMP_EN
    ,
    output logic [31:0]               rd_stamp
`endif
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int WDOG_W  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);
    localparam logic [WDOG_W-1:0]  WDOG_MAX   = '1;
    localparam logic [IDX_W:0]     RD_LIMIT   = (IDX_W + 1)'(NUM_CORES);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic [NUM_CORES-1:0] done_mask_q;
    logic [31:0]          code_q [NUM_CORES];
    logic                 any_fail_q;
    logic [IDX_W-1:0]     first_fail_q;
    logic [31:0]          rd_code_q;

    logic [NUM_CORES-1:0] exit_hit;
    logic [NUM_CORES-1:0] new_fail;
    logic [IDX_W-1:0]     fail_idx;
    logic                 detect_en;
    logic                 all_exited;
    logic                 unused_insn_bits;

    // Exit decode per core. Detection runs in RUN and DRAIN only, and a core
    // that has already exited is masked so its first code is the one kept.
    // The scan runs high-to-low so the lowest failing index wins a tie.
    always_comb begin
        exit_hit         = '0;
        new_fail         = '0;
        fail_idx         = '0;
        unused_insn_bits = 1'b0;
        detect_en        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        for (int i = 0; i < NUM_CORES; i++) begin
            exit_hit[i] = detect_en && trace_valid[i] && !done_mask_q[i] &&
                          (trace_insn[32*i+24 +: 8] == 8'h15) &&
                          (trace_insn[32*i +: 16] == NOP_EXIT);
            new_fail[i] = exit_hit[i] && (trace_r3[32*i +: 32] != 32'h0);
            unused_insn_bits = unused_insn_bits ^ (^trace_insn[32*i+16 +: 8]);
        end
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (new_fail[i]) fail_idx = IDX_W'(i);
        end
    end

    // Completion looks at the mask including this cycle's exits, so the
    // drain count starts on the same edge the last done_mask bit rises and
    // all_done follows exactly DRAIN_CYCLES edges later. Completion is
    // checked before the watchdog so it wins a same-cycle race.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        wdog_d     = wdog_q;
        all_exited = &(done_mask_q | exit_hit);
        case (state_q)
            ST_RUN: begin
                if (all_exited) begin
                    wdog_d = '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end else if (WDOG_CYCLES != 0) begin
                    if (|trace_valid) begin
                        wdog_d = '0;
                    end else begin
                        if (wdog_q >= WDOG_LAST) state_d = ST_TIMEOUT;
                        if (wdog_q != WDOG_MAX) wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q <= DRAIN_W'(1)) begin
                    state_d = ST_DONE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE:    state_d = ST_DONE;
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
    end

    // FSM, drain and watchdog registers; clear behaves like a synchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            drain_q <= '0;
            wdog_q  <= '0;
        end else if (clear) begin
            state_q <= ST_RUN;
            drain_q <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            wdog_q  <= wdog_d;
        end
    end

    // Exit latching. any_fail only has to OR in new failures because latched
    // codes never change; first_fail is captured while any_fail is still low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_mask_q  <= '0;
            any_fail_q   <= 1'b0;
            first_fail_q <= '0;
            for (int i = 0; i < NUM_CORES; i++) code_q[i] <= '0;
        end else if (clear) begin
            done_mask_q  <= '0;
            any_fail_q   <= 1'b0;
            first_fail_q <= '0;
            for (int i = 0; i < NUM_CORES; i++) code_q[i] <= '0;
        end else begin
            done_mask_q <= done_mask_q | exit_hit;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (exit_hit[i]) code_q[i] <= trace_r3[32*i +: 32];
            end
            if (|new_fail) any_fail_q <= 1'b1;
            if (!any_fail_q && (|new_fail)) first_fail_q <= fail_idx;
        end
    end

    // Registered readback; indices past the last core read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_code_q <= '0;
        end else if (clear) begin
            rd_code_q <= '0;
        end else if ({1'b0, rd_idx} < RD_LIMIT) begin
            rd_code_q <= code_q[rd_idx];
        end else begin
            rd_code_q <= '0;
        end
    end

`ifdef TERM_MONITOR_CYCLE_STAMP_EN
    logic [31:0] cycle_q;
    logic [31:0] stamp_q [NUM_CORES];
    logic [31:0] rd_stamp_q;

    // Saturating cycle counter and per-core exit stamps, read through rd_idx
    // alongside rd_code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q    <= '0;
            rd_stamp_q <= '0;
            for (int i = 0; i < NUM_CORES; i++) stamp_q[i] <= '0;
        end else if (clear) begin
            cycle_q    <= '0;
            rd_stamp_q <= '0;
            for (int i = 0; i < NUM_CORES; i++) stamp_q[i] <= '0;
        end else begin
            if (cycle_q != 32'hFFFF_FFFF) cycle_q <= cycle_q + 32'd1;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (exit_hit[i]) stamp_q[i] <= cycle_q;
            end
            if ({1'b0, rd_idx} < RD_LIMIT) rd_stamp_q <= stamp_q[rd_idx];
            else rd_stamp_q <= '0;
        end
    end

    assign rd_stamp = rd_stamp_q;
`endif

    assign done_mask      = done_mask_q;
    assign any_fail       = any_fail_q;
    assign first_fail_idx = first_fail_q;
    assign rd_code        = rd_code_q;
    assign all_done       = (state_q == ST_DONE);
    assign timeout        = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_term_monitor_multi.sv
// Testbench for term_monitor_multi with four cores, a 16-cycle drain and a
// 100-cycle watchdog. Expected values are pushed into a scoreboard queue when
// stimulus is applied and popped when the corresponding output is sampled.

module tb_term_monitor_multi;

    localparam int NC = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     trace_valid;
    logic [NC*32-1:0]  trace_insn;
    logic [NC*32-1:0]  trace_r3;
    logic              clear;
    logic [NC-1:0]     done_mask;
    logic              all_done;
    logic              any_fail;
    logic [IW-1:0]     first_fail_idx;
    logic              timeout;
    logic [IW-1:0]     rd_idx;
    logic [31:0]       rd_code;
`ifdef TERM_MONITOR_CYCLE_STAMP_EN
    logic [31:0]       rd_stamp;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    term_monitor_multi #(
        .NUM_CORES    (NC),
        .NOP_EXIT     (16'h0001),
        .DRAIN_CYCLES (16),
        .WDOG_CYCLES  (100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trace_valid    (trace_valid),
        .trace_insn     (trace_insn),
        .trace_r3       (trace_r3),
        .clear          (clear),
        .done_mask      (done_mask),
        .all_done       (all_done),
        .any_fail       (any_fail),
        .first_fail_idx (first_fail_idx),
        .timeout        (timeout),
        .rd_idx         (rd_idx),
        .rd_code        (rd_code)
`ifdef TERM_MONITOR_CYCLE_STAMP_EN
        ,
        .rd_stamp       (rd_stamp)
`endif
    );

    // Queue an expected value in the order it will be checked.
    task automatic expectVal(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the sampled output.
    task automatic checkOutput(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance n clock edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one retired instruction on a core: opcode byte, immediate, r3.
    task automatic applyStimulus(input int core, input logic [7:0] opc,
                                 input logic [15:0] imm, input logic [31:0] r3);
        trace_valid[core]        = 1'b1;
        trace_insn[32*core +: 32] = {opc, 8'h00, imm};
        trace_r3[32*core +: 32]   = r3;
    endtask

    task automatic idleTrace();
        trace_valid = '0;
        trace_insn  = '0;
        trace_r3    = '0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        clear  = 1'b0;
        rd_idx = '0;
        idleTrace();
        #12;

        // Reset state
        expectVal("rst_done_mask", 32'h0);
        expectVal("rst_all_done", 32'h0);
        expectVal("rst_any_fail", 32'h0);
        expectVal("rst_first_fail", 32'h0);
        expectVal("rst_timeout", 32'h0);
        expectVal("rst_rd_code", 32'h0);
        checkOutput(32'(done_mask));
        checkOutput(32'(all_done));
        checkOutput(32'(any_fail));
        checkOutput(32'(first_fail_idx));
        checkOutput(32'(timeout));
        checkOutput(rd_code);
        @(negedge clk);
        rst_n = 1'b1;

        // Staggered exits, all clean, then exact drain length
        step(9);
        for (int k = 0; k < NC; k++) begin
            applyStimulus(k, 8'h15, 16'h0001, 32'h0);
            step(1);
            idleTrace();
            if (k < NC - 1) step(9);
        end
        expectVal("seq_done_mask", 32'hF);
        expectVal("seq_all_done_early", 32'h0);
        checkOutput(32'(done_mask));
        checkOutput(32'(all_done));
        step(15);
        expectVal("drain_all_done_15", 32'h0);
        checkOutput(32'(all_done));
        step(1);
        expectVal("drain_all_done_16", 32'h1);
        expectVal("seq_any_fail", 32'h0);
        expectVal("seq_timeout", 32'h0);
        checkOutput(32'(all_done));
        checkOutput(32'(any_fail));
        checkOutput(32'(timeout));

        // Trace in DONE is ignored
        applyStimulus(0, 8'h15, 16'h0001, 32'h7);
        expectVal("done_ignores_any_fail", 32'h0);
        step(1);
        idleTrace();
        checkOutput(32'(any_fail));
        pulseClear();
        expectVal("clear_all_done", 32'h0);
        expectVal("clear_done_mask", 32'h0);
        checkOutput(32'(all_done));
        checkOutput(32'(done_mask));

        // Simultaneous failing exits on cores 2 and 1
        applyStimulus(2, 8'h15, 16'h0001, 32'h5);
        applyStimulus(1, 8'h15, 16'h0001, 32'h7);
        expectVal("sim_done_mask", 32'h6);
        expectVal("sim_any_fail", 32'h1);
        expectVal("sim_first_fail", 32'h1);
        expectVal("rd_code_core2", 32'h5);
        expectVal("rd_code_core1", 32'h7);
        step(1);
        idleTrace();
        checkOutput(32'(done_mask));
        checkOutput(32'(any_fail));
        checkOutput(32'(first_fail_idx));
        rd_idx = 2'd2;
        step(1);
        checkOutput(rd_code);
        rd_idx = 2'd1;
        step(1);
        checkOutput(rd_code);

        // Later failures do not move first_fail_idx
        applyStimulus(3, 8'h15, 16'h0001, 32'h9);
        expectVal("later_first_fail", 32'h1);
        expectVal("later_done_mask", 32'hE);
        step(1);
        idleTrace();
        checkOutput(32'(first_fail_idx));
        checkOutput(32'(done_mask));
        applyStimulus(0, 8'h15, 16'h0001, 32'h0);
        step(3);
        idleTrace();
        pulseClear();
        expectVal("clear_from_drain_done_mask", 32'h0);
        expectVal("clear_from_drain_any_fail", 32'h0);
        expectVal("clear_from_drain_first_fail", 32'h0);
        checkOutput(32'(done_mask));
        checkOutput(32'(any_fail));
        checkOutput(32'(first_fail_idx));
        step(20);
        expectVal("clear_from_drain_all_done", 32'h0);
        checkOutput(32'(all_done));

        // Repeated exit keeps first code; non-exit instructions ignored
        applyStimulus(0, 8'h15, 16'h0001, 32'h3);
        expectVal("rep_first_done_mask", 32'h1);
        step(1);
        idleTrace();
        checkOutput(32'(done_mask));
        applyStimulus(0, 8'h15, 16'h0001, 32'h9);
        applyStimulus(1, 8'h15, 16'h0002, 32'h4);
        applyStimulus(2, 8'h14, 16'h0001, 32'h4);
        expectVal("nonexit_done_mask", 32'h1);
        expectVal("rep_first_fail", 32'h0);
        expectVal("rep_rd_code_core0", 32'h3);
        step(1);
        idleTrace();
        checkOutput(32'(done_mask));
        checkOutput(32'(first_fail_idx));
        rd_idx = 2'd0;
        step(1);
        checkOutput(rd_code);

        // Watchdog counts from the last valid trace cycle
        step(98);
        expectVal("wdog_timeout_99", 32'h0);
        checkOutput(32'(timeout));
        step(1);
        expectVal("wdog_timeout_100", 32'h1);
        expectVal("wdog_all_done", 32'h0);
        checkOutput(32'(timeout));
        checkOutput(32'(all_done));
        pulseClear();
        expectVal("wdog_clear_timeout", 32'h0);
        checkOutput(32'(timeout));

        // Watchdog with no trace at all since restart
        step(99);
        expectVal("idle_timeout_99", 32'h0);
        checkOutput(32'(timeout));
        step(1);
        expectVal("idle_timeout_100", 32'h1);
        checkOutput(32'(timeout));
        pulseClear();

        // Clear wins over a same-cycle exit
        clear = 1'b1;
        applyStimulus(0, 8'h15, 16'h0001, 32'h3);
        expectVal("clear_vs_exit_done_mask", 32'h0);
        step(1);
        clear = 1'b0;
        idleTrace();
        checkOutput(32'(done_mask));

        // Asynchronous reset during DRAIN
        for (int k = 0; k < NC; k++) applyStimulus(k, 8'h15, 16'h0001, (k == 2) ? 32'h4 : 32'h0);
        rd_idx = 2'd2;
        expectVal("drain_done_mask", 32'hF);
        expectVal("drain_any_fail", 32'h1);
        expectVal("drain_first_fail", 32'h2);
        expectVal("drain_rd_code", 32'h4);
        step(1);
        idleTrace();
        checkOutput(32'(done_mask));
        checkOutput(32'(any_fail));
        checkOutput(32'(first_fail_idx));
        step(1);
        checkOutput(rd_code);
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        expectVal("async_done_mask", 32'h0);
        expectVal("async_any_fail", 32'h0);
        expectVal("async_first_fail", 32'h0);
        expectVal("async_rd_code", 32'h0);
        expectVal("async_all_done", 32'h0);
        expectVal("async_timeout", 32'h0);
        checkOutput(32'(done_mask));
        checkOutput(32'(any_fail));
        checkOutput(32'(first_fail_idx));
        checkOutput(rd_code);
        checkOutput(32'(all_done));
        checkOutput(32'(timeout));
        @(negedge clk);
        rst_n = 1'b1;

`ifdef TERM_MONITOR_CYCLE_STAMP_EN
        // Exit stamp: core 3 exits 250 cycles after reset, core 0 keeps the
        // watchdog alive with non-exit trace.
        trace_valid[0] = 1'b1;
        step(250);
        applyStimulus(3, 8'h15, 16'h0001, 32'h0);
        expectVal("stamp_core3", 32'd250);
        step(1);
        idleTrace();
        rd_idx = 2'd3;
        step(1);
        checkOutput(rd_stamp);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
